tx_feeder: RTL and testbench

- Byte-wide transmit buffer and sequencer that sits directly upstream of the USRT transmit shifter.
- Accepts bytes from the host/bus side into a FIFO and presents them one at a time on the shifter's enable/data inputs.
- Holds each byte until the shifter signals completion on its ready output, then advances to the next byte.
- Removes the need for the host to track per-byte transmit completion.

---
 rtl/tx_feeder.sv | 143 ++++++++++++++
 tb/tb_tx_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tx_feeder
// Purpose  : Byte FIFO plus sequencer that feeds the USRT transmit shifter one
//            byte at a time, advancing on each rising edge of shifter ready.
// Revision : 1.0 - initial release
// ============================================================================
module tx_feeder #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic              i_Pclk,
  input  logic              i_Presetn,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_Enable,
  output logic [7:0]        o_Tx_Data,
  input  logic              i_Tx_Pready,
  output logic              o_Busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W:0]  c_depth    = (ADDR_W + 1)'(DEPTH);
  localparam logic [GAP_W-1:0] c_gap_load = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [7:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic               r_overflow;
  logic               r_pready_d;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_tx_en;
  logic [7:0]         r_tx_data;

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_wr_drop;
  logic w_rise;
  logic w_pop;
  logic w_send_done;

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_wr_accept = i_Wr_En & ~w_full;
  // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_wr_drop   = i_Wr_En & w_full;
  // Only a fresh 0->1 transition of ready counts as completion.
  assign w_rise      = i_Tx_Pready & ~r_pready_d;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_send_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (w_rise) begin
          w_send_done  = 1'b1;
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  always_ff @(posedge i_Pclk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= i_Wr_Data;
  end

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_pready_d <= 1'b0;
      r_gap_cnt  <= '0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_pready_d <= i_Tx_Pready;
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)       r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr_accept, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_drop)      r_overflow <= 1'b1;
      else if (i_Clr_Ovf) r_overflow <= 1'b0;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_tx_en   <= 1'b1;
      end else if (w_send_done) begin
        r_tx_data <= '0;
        r_tx_en   <= 1'b0;
        r_gap_cnt <= c_gap_load;
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign o_Full      = w_full;
  assign o_Empty     = w_empty;
  assign o_Count     = r_count;
  assign o_Overflow  = r_overflow;
  assign o_Tx_Enable = r_tx_en;
  assign o_Tx_Data   = r_tx_data;
  assign o_Busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tx_feeder
// Purpose  : Directed scoreboard bench for tx_feeder with a ready-responding
//            shifter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_feeder;

  localparam int DEPTH      = 8;
  localparam int ADDR_W     = 3;
  localparam int GAP_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clr_ovf;
  logic             man_rdy;
  logic             auto_mode;
  logic             auto_rdy = 1'b0;
  logic             pready;
  logic             full, empty, ovf, tx_en, busy;
  logic [ADDR_W:0]  count;
  logic [7:0]       tx_data;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  bit         meas_gap  = 1'b0;
  bit         have_fall = 1'b0;
  int         low_cnt   = 0;
  logic       prev_en   = 1'b0;
  logic [7:0] held      = '0;
  int         hold      = 0;
  bit         rdy_pend  = 1'b0;

  always #5 clk = ~clk;

  assign pready = auto_mode ? auto_rdy : man_rdy;

  tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .i_Pclk      (clk),
    .i_Presetn   (rst_n),
    .i_Wr_En     (wr_en),
    .i_Wr_Data   (wr_data),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_Overflow  (ovf),
    .i_Clr_Ovf   (clr_ovf),
    .o_Tx_Enable (tx_en),
    .o_Tx_Data   (tx_data),
    .i_Tx_Pready (pready),
    .o_Busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !empty) && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 400), 1);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Scoreboard consumer: each new enable pulse must carry the next queued byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_en && !prev_en) begin
        if (meas_gap && have_fall) chk("gap_len", low_cnt, GAP_CYCLES + 1);
        if (sb.size() == 0) begin
          chk("unexpected_tx_sb_depth", sb.size(), 1);
          held = tx_data;
        end else begin
          held = sb.pop_front();
          chk("tx_data", 32'(tx_data), 32'(held));
        end
      end else if (tx_en && prev_en) begin
        chk("data_stable", 32'(tx_data), 32'(held));
      end
      if (!tx_en && prev_en) begin
        have_fall = 1'b1;
        low_cnt   = 1;
      end else if (!tx_en) begin
        low_cnt++;
      end
      prev_en = tx_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  // Shifter model: raises ready a few cycles into each enable pulse.
  always @(negedge clk) begin
    if (rdy_pend) begin
      chk("en_fall_after_rise", 32'(tx_en), 0);
      rdy_pend = 1'b0;
    end
    if (!auto_mode || !tx_en) begin
      auto_rdy = 1'b0;
      hold     = 0;
    end else if (!auto_rdy) begin
      if (hold == 3) begin
        auto_rdy = 1'b1;
        rdy_pend = 1'b1;
      end else begin
        hold++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;
    man_rdy = 1'b0; auto_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en",    32'(tx_en),   0);
    chk("rst_data",  32'(tx_data), 0);
    chk("rst_count", 32'(count),   0);
    chk("rst_empty", 32'(empty),   1);
    chk("rst_full",  32'(full),    0);
    chk("rst_ovf",   32'(ovf),     0);
    chk("rst_busy",  32'(busy),    0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single byte
    auto_mode = 1'b1;
    wr_en = 1'b1; wr_data = 8'h53; sb.push_back(8'h53);
    tick();
    wr_en = 1'b0;
    chk("single_count1", 32'(count), 1);
    chk("single_en_lo",  32'(tx_en), 0);
    chk("single_empty0", 32'(empty), 0);
    tick();
    chk("single_en_hi",  32'(tx_en),   1);
    chk("single_data",   32'(tx_data), 'h53);
    chk("single_busy",   32'(busy),    1);
    chk("single_count0", 32'(count),   0);
    wait_idle("single");

    // Burst of three
    meas_gap = 1'b1; have_fall = 1'b0;
    wr_en = 1'b1; wr_data = 8'h11; sb.push_back(8'h11);
    tick();
    chk("burst_count_a", 32'(count), 1);
    wr_data = 8'h22; sb.push_back(8'h22);
    tick();
    chk("burst_count_wr_pop", 32'(count), 1);
    wr_data = 8'h33; sb.push_back(8'h33);
    tick();
    chk("burst_count_c", 32'(count), 2);
    wr_en = 1'b0;
    wait_idle("burst");
    chk("burst_empty", 32'(empty), 1);
    meas_gap = 1'b0;

    // Overflow with the shifter stalled
    auto_mode = 1'b0; man_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(64 + i);
      if (i < 9) sb.push_back(8'(64 + i));
      tick();
      if (i == 1) chk("ovf_after_pop", 32'(count), 1);
      if (i == 8) begin
        chk("ovf_full",      32'(full),  1);
        chk("ovf_count8",    32'(count), 8);
        chk("ovf_not_yet",   32'(ovf),   0);
      end
      if (i == 9) begin
        chk("ovf_set",       32'(ovf),   1);
        chk("ovf_count_hold",32'(count), 8);
      end
    end
    wr_en = 1'b0; clr_ovf = 1'b1;
    tick();
    chk("ovf_cleared", 32'(ovf), 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    chk("ovf_set_wins", 32'(ovf), 1);
    wr_en = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr_again", 32'(ovf), 0);
    auto_mode = 1'b1;
    wait_idle("ovf_drain");

    // Stale ready level
    auto_mode = 1'b0; man_rdy = 1'b1;
    tick(); tick();
    wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    repeat (5) tick();
    chk("stale_en_hi",  32'(tx_en),   1);
    chk("stale_busy",   32'(busy),    1);
    chk("stale_data",   32'(tx_data), 'hA5);
    man_rdy = 1'b0;
    tick(); tick();
    chk("stale_low_hold", 32'(tx_en), 1);
    man_rdy = 1'b1;
    tick();
    chk("stale_rise_en_lo", 32'(tx_en), 0);
    chk("stale_gap_busy",   32'(busy),  1);
    man_rdy = 1'b0;
    wait_idle("stale");

    // Reset mid-transfer
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(160 + i); sb.push_back(8'(160 + i));
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("mid_busy",  32'(busy),  1);
    chk("mid_count", 32'(count), 3);
    chk("mid_en",    32'(tx_en), 1);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_en",    32'(tx_en),   0);
    chk("arst_data",  32'(tx_data), 0);
    chk("arst_count", 32'(count),   0);
    chk("arst_empty", 32'(empty),   1);
    chk("arst_busy",  32'(busy),    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_en",    32'(tx_en), 0);
    chk("post_rst_busy",  32'(busy),  0);
    chk("post_rst_empty", 32'(empty), 1);

    // Wrap-around in groups of five
    auto_mode = 1'b1; meas_gap = 1'b1;
    for (int g = 0; g < 4; g++) begin
      have_fall = 1'b0;
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; wr_data = 8'(5 * g + i); sb.push_back(8'(5 * g + i));
        tick();
        chk("wrap_count", 32'(count), (i == 0) ? 1 : i);
      end
      wr_en = 1'b0;
      wait_idle("wrap");
    end
    meas_gap = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
